// File: rtl/spawn_scheduler_pkg.sv
// Shared definitions for the spawn path: enemy kind encodings, default
// spawn geometry per kind, and the level/speed widths seen by the slot
// table and renderer.
package spawn_scheduler_pkg;

  localparam int LEVEL_W = 3;
  localparam int SPEED_W = 4;
  localparam int Y_W     = 10;
  localparam int SZ_W    = 8;
  localparam int GAP_W   = 8;

  typedef enum logic {
    KIND_GROUND = 1'b0,
    KIND_AIR    = 1'b1
  } kind_e;

  localparam logic [Y_W-1:0]  GROUND_Y_DEF = 10'd200;
  localparam logic [SZ_W-1:0] GROUND_W_DEF = 8'd16;
  localparam logic [SZ_W-1:0] GROUND_H_DEF = 8'd24;
  localparam logic [Y_W-1:0]  AIR_Y_DEF    = 10'd160;
  localparam logic [SZ_W-1:0] AIR_W_DEF    = 8'd20;
  localparam logic [SZ_W-1:0] AIR_H_DEF    = 8'd12;

  typedef struct packed {
    kind_e           kind;
    logic [Y_W-1:0]  y;
    logic [SZ_W-1:0] w;
    logic [SZ_W-1:0] h;
  } spawn_req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COOLDOWN,
    S_ARMED,
    S_REQUEST
  } sched_state_e;

endpackage

// File: rtl/spawn_scheduler_difficulty_ramp.sv
// Difficulty ramp: counts started frames, bumps the level every
// LEVEL_FRAMES frames (saturating at MAX_LEVEL), keeps speed registered
// alongside level, and derives the post-spawn cooldown for the current level.
// Ports: clk3/reset (async low), pause (hold), start (low clears),
//        level/speed (registered), gap (combinational from level).
module spawn_scheduler_difficulty_ramp
  import spawn_scheduler_pkg::*;
#(
  parameter int LEVEL_FRAMES = 600,
  parameter int MAX_LEVEL    = 7,
  parameter int BASE_SPEED   = 2,
  parameter int MIN_GAP      = 60,
  parameter int GAP_STEP     = 5,
  parameter int GAP_FLOOR    = 25
) (
  input  logic               clk3,
  input  logic               reset,
  input  logic               pause,
  input  logic               start,
  output logic [LEVEL_W-1:0] level,
  output logic [SPEED_W-1:0] speed,
  output logic [GAP_W-1:0]   gap
);

  localparam int FC_W = $clog2(LEVEL_FRAMES);

  logic [FC_W-1:0]  frame_cnt;
  logic [GAP_W-1:0] step;
  logic [GAP_W:0]   reach;

  // Clamp is decided on a 9-bit sum so the subtraction never wraps.
  always_comb begin
    step  = GAP_W'(GAP_STEP) * {{(GAP_W-LEVEL_W){1'b0}}, level};
    reach = {1'b0, step} + (GAP_W+1)'(GAP_FLOOR);
    if (reach >= (GAP_W+1)'(MIN_GAP)) gap = GAP_W'(GAP_FLOOR);
    else                              gap = GAP_W'(MIN_GAP) - step;
  end

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      level     <= '0;
      speed     <= SPEED_W'(BASE_SPEED);
    end else if (!pause) begin
      if (!start) begin
        frame_cnt <= '0;
        level     <= '0;
        speed     <= SPEED_W'(BASE_SPEED);
      end else if (frame_cnt == FC_W'(LEVEL_FRAMES-1)) begin
        frame_cnt <= '0;
        if (level != LEVEL_W'(MAX_LEVEL)) begin
          level <= level + LEVEL_W'(1);
          speed <= SPEED_W'(BASE_SPEED) + {{(SPEED_W-LEVEL_W){1'b0}}, level} + SPEED_W'(1);
        end
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// Frame-rate enemy spawn scheduler. Waits out a level-dependent cooldown,
// then rolls the per-frame random against a level-dependent threshold and,
// when a slot is free, presents one spawn request to the slot table over
// valid/ready. One clk3 cycle is one game frame.
// Ports: clk3/reset (async low); pause freezes everything; start low returns
//        to idle; randoms (per-frame LFSR); slot_free; spawn_ready;
//        spawn_valid + kind/y/w/h payload; speed, level.
module spawn_scheduler
  import spawn_scheduler_pkg::*;
#(
  parameter int              RND_W        = 16,
  parameter int              LEVEL_FRAMES = 600,
  parameter int              MAX_LEVEL    = 7,
  parameter int              BASE_SPEED   = 2,
  parameter int              MIN_GAP      = 60,
  parameter int              GAP_STEP     = 5,
  parameter int              GAP_FLOOR    = 25,
  parameter int              THRESH_BASE  = 8,
  parameter int              AIR_LEVEL    = 3,
  parameter logic [Y_W-1:0]  GROUND_Y     = GROUND_Y_DEF,
  parameter logic [SZ_W-1:0] GROUND_W     = GROUND_W_DEF,
  parameter logic [SZ_W-1:0] GROUND_H     = GROUND_H_DEF,
  parameter logic [Y_W-1:0]  AIR_Y        = AIR_Y_DEF,
  parameter logic [SZ_W-1:0] AIR_W        = AIR_W_DEF,
  parameter logic [SZ_W-1:0] AIR_H        = AIR_H_DEF
) (
  input  logic               clk3,
  input  logic               reset,
  input  logic               pause,
  input  logic               start,
  input  logic [RND_W-1:0]   randoms,
  input  logic               slot_free,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic               spawn_kind,
  output logic [Y_W-1:0]     spawn_y,
  output logic [SZ_W-1:0]    spawn_w,
  output logic [SZ_W-1:0]    spawn_h,
  output logic [SPEED_W-1:0] speed,
  output logic [LEVEL_W-1:0] level
);

  sched_state_e     state, state_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx, gap;
  spawn_req_t       req, req_nx;
  logic [7:0]       thresh;
  logic             hit, air_ok;
  logic             unused_rnd;

  spawn_scheduler_difficulty_ramp #(
    .LEVEL_FRAMES(LEVEL_FRAMES), .MAX_LEVEL(MAX_LEVEL), .BASE_SPEED(BASE_SPEED),
    .MIN_GAP(MIN_GAP), .GAP_STEP(GAP_STEP), .GAP_FLOOR(GAP_FLOOR)
  ) u_ramp (
    .clk3 (clk3),
    .reset(reset),
    .pause(pause),
    .start(start),
    .level(level),
    .speed(speed),
    .gap  (gap)
  );

  // Threshold grows by 4 per level; max 8+28 fits in 8 bits.
  assign thresh     = 8'(THRESH_BASE) + {3'b000, level, 2'b00};
  assign hit        = randoms[7:0] < thresh;
  assign air_ok     = level >= LEVEL_W'(AIR_LEVEL);
  assign unused_rnd = ^randoms[RND_W-1:9];

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
      req     <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
      req     <= req_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gap_nx   = gap_cnt;
    req_nx   = req;
    if (!pause) begin
      if (!start) begin
        // Dropping start abandons any pending request.
        state_nx = S_IDLE;
        gap_nx   = '0;
      end else begin
        case (state)
          S_IDLE: begin
            state_nx = S_COOLDOWN;
            gap_nx   = gap;
          end
          S_COOLDOWN: begin
            if (gap_cnt <= GAP_W'(1)) begin
              gap_nx   = '0;
              state_nx = S_ARMED;
            end else begin
              gap_nx = gap_cnt - GAP_W'(1);
            end
          end
          S_ARMED: begin
            // A hit with no free slot is simply lost, not deferred.
            if (hit && slot_free) begin
              state_nx = S_REQUEST;
              if (air_ok && randoms[8]) begin
                req_nx = '{kind: KIND_AIR, y: AIR_Y, w: AIR_W, h: AIR_H};
              end else begin
                req_nx = '{kind: KIND_GROUND, y: GROUND_Y, w: GROUND_W, h: GROUND_H};
              end
            end
          end
          S_REQUEST: begin
            if (spawn_ready) begin
              state_nx = S_COOLDOWN;
              gap_nx   = gap;
            end
          end
          default: state_nx = S_IDLE;
        endcase
      end
    end
  end

  assign spawn_valid = (state == S_REQUEST) && !pause;
  assign spawn_kind  = req.kind;
  assign spawn_y     = req.y;
  assign spawn_w     = req.w;
  assign spawn_h     = req.h;

endmodule
